// File: rtl/kernel_reader.sv
// Kernel RAM read sequencer: start/end/repeat address walk into a 2-entry output FIFO.
// Optional macro KERNEL_READER_REPEAT_EN enables multi-pass repeat support.
module kernel_reader #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int DEPTH_NB   = 16,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [MEM_AWIDTH-1:0]                   rd_cfg_start,
    input  logic [MEM_AWIDTH-1:0]                   rd_cfg_end,
    input  logic [15:0]                             rd_cfg_rep,
    input  logic                                    rd_cfg_set,
    output logic                                    mem_rd_en,
    output logic [MEM_AWIDTH-1:0]                   mem_rd_addr,
    input  logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0]  mem_rd_data,
    output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0]  kernel,
    output logic                                    kernel_val,
    input  logic                                    kernel_rdy,
    output logic                                    kernel_last,
    output logic                                    busy
);

    localparam int KWIDTH = GROUP_NB*KER_WIDTH*DEPTH_NB;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [MEM_AWIDTH-1:0] start_q, end_q;
    logic [MEM_AWIDTH-1:0] addr_q, addr_d;

`ifdef KERNEL_READER_REPEAT_EN
    logic [15:0] rep_q;
    logic [15:0] pass_q, pass_d;
`else
    logic unused_rep;
    assign unused_rep = ^rd_cfg_rep;
`endif

    logic              infl_q;
    logic              infl_last_q;
    logic [KWIDTH-1:0] buf_q [2];
    logic [1:0]        last_buf_q;
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        cnt_q;

    logic       pop;
    logic       push;
    logic [1:0] occ_net;
    logic       rd_ok;
    logic       at_end;
    logic       final_rd;

    assign pop  = kernel_val & kernel_rdy;
    assign push = infl_q;

    // Occupancy after this cycle's pop, including the read already in flight.
    assign occ_net = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    assign rd_ok   = (occ_net < 2'd2);
    assign at_end  = (addr_q == end_q);

`ifdef KERNEL_READER_REPEAT_EN
    assign final_rd = at_end && (pass_q == rep_q);
`else
    assign final_rd = at_end;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mem_rd_en = 1'b0;
`ifdef KERNEL_READER_REPEAT_EN
        pass_d    = pass_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rd_cfg_set) begin
                    addr_d  = rd_cfg_start;
`ifdef KERNEL_READER_REPEAT_EN
                    pass_d  = 16'd0;
`endif
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_ok) begin
                    mem_rd_en = 1'b1;
                    if (final_rd) begin
                        state_d = DRAIN;
                    end else if (at_end) begin
                        addr_d = start_q;
`ifdef KERNEL_READER_REPEAT_EN
                        pass_d = pass_q + 16'd1;
`endif
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!infl_q && occ_net == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= '0;
            end_q       <= '0;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            last_buf_q  <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
`ifdef KERNEL_READER_REPEAT_EN
            rep_q       <= '0;
            pass_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            infl_q      <= mem_rd_en;
            infl_last_q <= mem_rd_en & at_end;
`ifdef KERNEL_READER_REPEAT_EN
            pass_q      <= pass_d;
`endif
            if (state_q == IDLE && rd_cfg_set) begin
                start_q <= rd_cfg_start;
                end_q   <= rd_cfg_end;
`ifdef KERNEL_READER_REPEAT_EN
                rep_q   <= rd_cfg_rep;
`endif
            end
            if (push) begin
                buf_q[wr_ptr_q]      <= mem_rd_data;
                last_buf_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign mem_rd_addr = addr_q;
    assign kernel_val  = (cnt_q != 2'd0);
    assign kernel      = buf_q[rd_ptr_q];
    assign kernel_last = kernel_val & last_buf_q[rd_ptr_q];
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_kernel_reader.sv
// Scoreboard bench for kernel_reader: synthetic RAM, handshake monitor, credit model.
// Expected repeat behaviour follows KERNEL_READER_REPEAT_EN.
module tb_kernel_reader;

    localparam int KW = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   rd_cfg_start;
    logic [15:0]   rd_cfg_end;
    logic [15:0]   rd_cfg_rep;
    logic          rd_cfg_set;
    logic          mem_rd_en;
    logic [15:0]   mem_rd_addr;
    logic [KW-1:0] mem_rd_data;
    logic [KW-1:0] kernel;
    logic          kernel_val;
    logic          kernel_rdy;
    logic          kernel_last;
    logic          busy;

    kernel_reader dut (
        .clk          (clk),
        .rst          (rst),
        .rd_cfg_start (rd_cfg_start),
        .rd_cfg_end   (rd_cfg_end),
        .rd_cfg_rep   (rd_cfg_rep),
        .rd_cfg_set   (rd_cfg_set),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .kernel       (kernel),
        .kernel_val   (kernel_val),
        .kernel_rdy   (kernel_rdy),
        .kernel_last  (kernel_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        last;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ph = 0;
    int rdy_mode = 0;
    int hs_cnt = 0;
    int first_hs = 0;
    int last_hs = 0;
    int extra = 0;
    int set_cyc = 0;
    int occ_m = 0;
    logic infl_m = 1'b0;
    logic hold_v = 1'b0;
    logic hold_l = 1'b0;
    logic [KW-1:0] hold_k = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] mk(input logic [15:0] a);
        return {32{~a, a}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mk(mem_rd_addr);
        else           mem_rd_data <= {32{32'hDEADBEEF}};
    end

    initial begin
        kernel_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            if (rdy_mode == 0) kernel_rdy = 1'b1;
            else kernel_rdy = (ph % 4 == 0) || (ph % 4 == 3);
        end
    end

    always @(negedge clk) begin
        logic pop;
        exp_t e;
        pop = kernel_val && kernel_rdy;
        if (rst) begin
            hold_v = 1'b0;
            occ_m  = 0;
            infl_m = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_val", kernel_val, 1);
                check("stall_data", kernel == hold_k, 1);
                check("stall_last", kernel_last, hold_l);
            end
            hold_v = kernel_val && !kernel_rdy;
            hold_k = kernel;
            hold_l = kernel_last;
            if (mem_rd_en)
                check("credit", (occ_m + int'(infl_m) - int'(pop)) < 2, 1);
            if (pop) begin
                hs_cnt++;
                if (hs_cnt == 1) first_hs = cyc;
                last_hs = cyc;
                if (sb.size() == 0) begin
                    extra++;
                end else begin
                    e = sb.pop_front();
                    check("addr", kernel[15:0], e.addr);
                    check("word", kernel == mk(e.addr), 1);
                    check("last", kernel_last, e.last);
                end
            end
            occ_m  = occ_m + int'(infl_m) - int'(pop);
            infl_m = mem_rd_en;
        end
    end

    task automatic push_seq(input logic [15:0] s, input logic [15:0] e,
                            input int passes, output int n);
        logic [15:0] a;
        n = 0;
        for (int p = 0; p < passes; p++) begin
            a = s;
            forever begin
                sb.push_back('{a, a == e});
                n++;
                if (a == e) break;
                a = a + 16'd1;
            end
        end
    endtask

    task automatic start_cfg(input logic [15:0] s, input logic [15:0] e,
                             input logic [15:0] rep);
        @(posedge clk);
        #1;
        rd_cfg_start = s;
        rd_cfg_end   = e;
        rd_cfg_rep   = rep;
        rd_cfg_set   = 1'b1;
        set_cyc      = cyc;
        @(posedge clk);
        #1;
        rd_cfg_set = 1'b0;
        @(negedge clk);
        check("busy_c1", busy, 1);
        check("rden_c1", mem_rd_en, 1);
        check("addr_c1", mem_rd_addr, s);
    endtask

    task automatic run(input logic [15:0] s, input logic [15:0] e,
                       input logic [15:0] rep, input int mode,
                       input bit inj, input bit timing);
        int passes;
        int n;
        bit done;
`ifdef KERNEL_READER_REPEAT_EN
        passes = int'(rep) + 1;
`else
        passes = 1;
`endif
        sb.delete();
        push_seq(s, e, passes, n);
        rdy_mode = mode;
        hs_cnt   = 0;
        extra    = 0;
        start_cfg(s, e, rep);
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (inj && k == 2) begin
                rd_cfg_start = 16'd100;
                rd_cfg_end   = 16'd110;
                rd_cfg_rep   = 16'd1;
                rd_cfg_set   = 1'b1;
            end
            if (inj && k == 3) rd_cfg_set = 1'b0;
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        rd_cfg_set = 1'b0;
        check("timeout", done, 1);
        if (done) check("busy_fall", cyc - last_hs, 1);
        check("count", hs_cnt, n);
        check("sb_empty", sb.size(), 0);
        check("extra", extra, 0);
        if (timing) begin
            check("latency", first_hs - set_cyc, 3);
            check("no_bubble", last_hs - first_hs, n - 1);
        end
        repeat (2) @(negedge clk);
        check("idle_rden", mem_rd_en, 0);
    endtask

    initial begin
        int n;
        bit got3;
        rst          = 1'b1;
        rd_cfg_start = '0;
        rd_cfg_end   = '0;
        rd_cfg_rep   = '0;
        rd_cfg_set   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rden", mem_rd_en, 0);
        check("rst_addr", mem_rd_addr, 0);
        check("rst_kernel", kernel == '0, 1);
        check("rst_val", kernel_val, 0);
        check("rst_last", kernel_last, 0);
        check("rst_busy", busy, 0);

        run(16'd4, 16'd7, 16'd0, 0, 1'b0, 1'b1);
        run(16'd10, 16'd11, 16'd2, 0, 1'b0, 1'b1);
        run(16'hFFFE, 16'h0001, 16'd0, 0, 1'b0, 1'b1);
        run(16'd0, 16'd7, 16'd0, 1, 1'b0, 1'b0);
        run(16'd30, 16'd37, 16'd0, 0, 1'b1, 1'b1);

        sb.delete();
        push_seq(16'd40, 16'd49, 1, n);
        rdy_mode = 0;
        hs_cnt   = 0;
        extra    = 0;
        start_cfg(16'd40, 16'd49, 16'd0);
        got3 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (hs_cnt >= 3) begin
                got3 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_wait3", got3, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rden", mem_rd_en, 0);
        check("mid_addr", mem_rd_addr, 0);
        check("mid_kernel", kernel == '0, 1);
        check("mid_val", kernel_val, 0);
        check("mid_last", kernel_last, 0);
        check("mid_busy", busy, 0);
        @(negedge clk);
        check("mid_discard", kernel_val, 0);
        check("mid_noread", mem_rd_en, 0);
        check("mid_extra", extra, 0);

        run(16'd20, 16'd20, 16'd0, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
